// File: rtl/uart_rx_packetizer.sv
// Packs UART rx bytes into packets (closed on idle gap or length cap) behind a first-word-fall-through FIFO.
// The input never stalls: a byte leaves the hold stage once its tlast is known, and a push into a full FIFO is dropped and counted.
module uart_rx_packetizer #(
    parameter int DEPTH        = 16,
    parameter int MAX_PKT_LEN  = 64,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic [15:0]            drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int IW = $clog2(IDLE_TIMEOUT);
    localparam logic [15:0]   PKT_MAX   = 16'(MAX_PKT_LEN);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    typedef enum logic {ST_EMPTY, ST_HOLD} state_e;

    state_e        state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          flush;
    logic          push_vld;
    beat_t         push_beat;

    beat_t         mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_count_q, drop_count_d;
    logic          pop;
    logic          push_ok;
    logic          drop;
    beat_t         head;

    assign flush = (state_q == ST_HOLD) &&
                   ((pkt_cnt_q == PKT_MAX) || (idle_cnt_q == IDLE_LAST));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (s_axis_tvalid) state_d = ST_HOLD;
            ST_HOLD:  if (flush && !s_axis_tvalid) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // A new byte always pushes the held one; flush only decides its last bit and the packet count.
    always_comb begin
        push_vld   = 1'b0;
        push_beat  = '0;
        hold_d     = hold_q;
        pkt_cnt_d  = pkt_cnt_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            ST_EMPTY: begin
                if (s_axis_tvalid) begin
                    hold_d     = s_axis_tdata;
                    pkt_cnt_d  = pkt_cnt_q + 16'd1;
                    idle_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (s_axis_tvalid) begin
                    push_vld   = 1'b1;
                    push_beat  = '{last: flush, data: hold_q};
                    hold_d     = s_axis_tdata;
                    pkt_cnt_d  = flush ? 16'd1 : pkt_cnt_q + 16'd1;
                    idle_cnt_d = '0;
                end else if (flush) begin
                    push_vld   = 1'b1;
                    push_beat  = '{last: 1'b1, data: hold_q};
                    pkt_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            pkt_cnt_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            hold_q     <= hold_d;
            pkt_cnt_q  <= pkt_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop     = (level_q != '0) && m_axis_tready;
    assign push_ok = push_vld && ((level_q < LVL_FULL) || pop);
    assign drop    = push_vld && !push_ok;

    always_comb begin
        rd_ptr_d     = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d     = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (push_ok && !pop) level_d = level_q + LW'(1);
        if (pop && !push_ok) level_d = level_q - LW'(1);
        if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_d != 16'hFFFF) drop_count_d = drop_count_d + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_beat;
    end

    assign head          = mem_q[rd_ptr_q];
    assign m_axis_tvalid = (level_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head.data : 8'h00;
    assign m_axis_tlast  = m_axis_tvalid ? head.last : 1'b0;
    assign overflow      = overflow_q;
    assign drop_count    = drop_count_q;
    assign fifo_level    = level_q;

endmodule
